// File: rtl/sad_trigger_engine_if.sv
// Reference-sample write bus into the SAD trigger engine.
// The master (register side) loads one reference slot per cycle.
interface sad_trigger_engine_if #(
    parameter int pREF_SAMPLES     = 32,
    parameter int pBITS_PER_SAMPLE = 12
) ();
    logic                            ref_wr;
    logic [$clog2(pREF_SAMPLES)-1:0] ref_addr;
    logic [pBITS_PER_SAMPLE-1:0]     ref_data;

    modport master (output ref_wr, output ref_addr, output ref_data);
    modport slave  (input  ref_wr, input  ref_addr, input  ref_data);
endinterface

// File: rtl/sad_trigger_engine.sv
// Sliding-window SAD trigger: per-slot |x-ref| with exclude mask, registered adder tree,
// one-shot/continuous arming with holdoff, running minimum SAD and trigger counter.
module sad_trigger_engine #(
    parameter int pREF_SAMPLES     = 32,
    parameter int pBITS_PER_SAMPLE = 12,
    parameter int pSAD_WIDTH       = 20,
    parameter int pHOLDOFF_WIDTH   = 16,
    parameter int pTRIG_CNT_WIDTH  = 16
) (
    input  logic                       i_clk_adc,
    input  logic                       i_reset_n,
    input  logic [pBITS_PER_SAMPLE-1:0] i_adc_datain,
    sad_trigger_engine_if.slave        ref_bus,
    input  logic [pREF_SAMPLES-1:0]    i_exclude,
    input  logic [pSAD_WIDTH-1:0]      i_threshold,
    input  logic                       i_arm,
    input  logic                       i_always_armed,
    input  logic [pHOLDOFF_WIDTH-1:0]  i_holdoff,
    input  logic                       i_sad_min_clear,
    output logic                       o_armed,
    output logic                       o_trigger,
    output logic [pSAD_WIDTH-1:0]      o_sad_out,
    output logic [pSAD_WIDTH-1:0]      o_sad_min,
    output logic [pTRIG_CNT_WIDTH-1:0] o_trig_count
);
    localparam int N     = pREF_SAMPLES;
    localparam int B     = pBITS_PER_SAMPLE;
    localparam int S     = pSAD_WIDTH;
    localparam int LOG2N = $clog2(N);
    localparam logic [LOG2N:0] FULL  = (LOG2N+1)'(N);
    localparam logic [0:0]     IDLE  = 1'b0;
    localparam logic [0:0]     ARMED = 1'b1;

    if (S < B + LOG2N) begin : g_bad_sad_width
        $error("pSAD_WIDTH too narrow for pREF_SAMPLES x pBITS_PER_SAMPLE");
    end
    if ((N < 2) || ((1 << LOG2N) != N)) begin : g_bad_n
        $error("pREF_SAMPLES must be a power of two >= 2");
    end

    function automatic logic [B-1:0] abs_diff(input logic [B-1:0] a, input logic [B-1:0] b);
        logic signed [B:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return d[B] ? B'(-d) : d[B-1:0];
    endfunction

    logic [B-1:0]     r_win  [N];
    logic [B-1:0]     r_ref  [N];
    logic [S-1:0]     r_node [2:2*N-1];
    logic [S-1:0]     r_sad;
    logic [S-1:0]     r_sad_min;
    logic [LOG2N:0]   r_fill;
    logic             r_fill_en;
    logic [LOG2N:0]   r_vld_p;
    logic [0:0]       r_state;
    logic [pHOLDOFF_WIDTH-1:0]  r_hold;
    logic             r_trig;
    logic [pTRIG_CNT_WIDTH-1:0] r_cnt;
    logic             w_win_vld;
    logic             w_fire;

    // Capture stage: slot N-1 holds the newest sample, slot 0 the oldest.
    always_ff @(posedge i_clk_adc) begin
        for (int i = 0; i < N-1; i++) r_win[i] <= r_win[i+1];
        r_win[N-1] <= i_adc_datain;
    end

    always_ff @(posedge i_clk_adc or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < N; i++) r_ref[i] <= '0;
        end else if (ref_bus.ref_wr) begin
            r_ref[ref_bus.ref_addr] <= ref_bus.ref_data;
        end
    end

    // Heap-ordered tree: leaves N..2N-1 are the |x-ref| stage, node j sums 2j and 2j+1.
    always_ff @(posedge i_clk_adc) begin
        for (int i = 0; i < N; i++)
            r_node[N+i] <= i_exclude[i] ? '0 : S'(abs_diff(r_win[i], r_ref[i]));
        for (int j = 2; j < N; j++)
            r_node[j] <= r_node[2*j] + r_node[2*j+1];
    end

    assign w_win_vld = r_fill_en && (r_fill == FULL);
    assign w_fire    = r_vld_p[LOG2N] && (r_state == ARMED) && (r_hold == '0) &&
                       (r_sad < i_threshold);

    // Root of the tree doubles as sad_out; compare stage follows one edge later.
    always_ff @(posedge i_clk_adc or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= IDLE;
            r_fill_en <= 1'b0;
            r_fill    <= '0;
            r_vld_p   <= '0;
            r_hold    <= '0;
            r_trig    <= 1'b0;
            r_sad     <= '0;
            r_sad_min <= '1;
            r_cnt     <= '0;
        end else begin
            r_trig <= w_fire;
            if (w_fire) r_cnt <= r_cnt + 1'b1;
            if (i_sad_min_clear)
                r_sad_min <= '1;
            else if (r_vld_p[LOG2N] && (r_sad < r_sad_min))
                r_sad_min <= r_sad;
            if (r_vld_p[LOG2N-1] && !i_arm)
                r_sad <= r_node[2] + r_node[3];
            if (i_arm) begin
                // Re-arm restarts the fill and drops every window still in flight.
                r_state   <= ARMED;
                r_fill_en <= 1'b1;
                r_fill    <= '0;
                r_vld_p   <= '0;
                r_hold    <= '0;
            end else begin
                if (r_fill_en && (r_fill != FULL)) r_fill <= r_fill + 1'b1;
                r_vld_p <= {r_vld_p[LOG2N-1:0], w_win_vld};
                if (w_fire && i_always_armed)
                    r_hold <= i_holdoff;
                else if (r_hold != '0)
                    r_hold <= r_hold - 1'b1;
                if (w_fire && !i_always_armed) r_state <= IDLE;
            end
        end
    end

    assign o_armed      = (r_state == ARMED);
    assign o_trigger    = r_trig;
    assign o_sad_out    = r_sad;
    assign o_sad_min    = r_sad_min;
    assign o_trig_count = r_cnt;
endmodule

// File: tb/tb_sad_trigger_engine.sv
// Directed bench for sad_trigger_engine with N=8, B=12, S=20 (trigger latency 5).
module tb_sad_trigger_engine;
    localparam int N = 8, B = 12, S = 20, HW = 16, TW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [B-1:0]  adc;
    logic [N-1:0]  excl;
    logic [S-1:0]  thr;
    logic          arm, aa, clr;
    logic [HW-1:0] holdoff;
    logic          armed, trig;
    logic [S-1:0]  sad_out, sad_min;
    logic [TW-1:0] tcnt;
    int            n_cmp = 0, n_bad = 0;
    int            first, pulses;
    logic [S-1:0]  sad4;

    always #5 clk = ~clk;

    sad_trigger_engine_if #(.pREF_SAMPLES(N), .pBITS_PER_SAMPLE(B)) rbus ();

    sad_trigger_engine #(
        .pREF_SAMPLES(N), .pBITS_PER_SAMPLE(B), .pSAD_WIDTH(S),
        .pHOLDOFF_WIDTH(HW), .pTRIG_CNT_WIDTH(TW)
    ) dut (
        .i_clk_adc(clk), .i_reset_n(rst_n), .i_adc_datain(adc), .ref_bus(rbus),
        .i_exclude(excl), .i_threshold(thr), .i_arm(arm), .i_always_armed(aa),
        .i_holdoff(holdoff), .i_sad_min_clear(clr), .o_armed(armed), .o_trigger(trig),
        .o_sad_out(sad_out), .o_sad_min(sad_min), .o_trig_count(tcnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [B-1:0] s);
        adc = s;
        tick();
    endtask

    task automatic wr_ref(input int a, input logic [B-1:0] d);
        rbus.ref_wr = 1'b1;
        rbus.ref_addr = 3'(a);
        rbus.ref_data = d;
        tick();
        rbus.ref_wr = 1'b0;
    endtask

    task automatic load_refs(input bit flat);
        for (int i = 0; i < N; i++) wr_ref(i, flat ? 12'd500 : 12'(100 * (i + 1)));
    endtask

    task automatic arm_tick(input logic [B-1:0] s, input bit c);
        arm = 1'b1;
        clr = c;
        push(s);
        arm = 1'b0;
        clr = 1'b0;
    endtask

    // Reference pattern 100..800, optionally with one slot replaced.
    task automatic pattern(input int slot, input logic [B-1:0] v);
        for (int i = 0; i < N; i++) push(i == slot ? v : 12'(100 * (i + 1)));
    endtask

    task automatic watch(input int n, input logic [B-1:0] s,
                         output int f, output int p, output logic [S-1:0] s4);
        f = 0; p = 0; s4 = '0;
        for (int t = 1; t <= n; t++) begin
            push(s);
            if (trig) begin
                p++;
                if (f == 0) f = t;
            end
            if (t == 4) s4 = sad_out;
        end
    endtask

    initial begin
        adc = '0; excl = '0; thr = 20'd1; arm = 1'b0; aa = 1'b0; clr = 1'b0; holdoff = '0;
        rbus.ref_wr = 1'b0; rbus.ref_addr = '0; rbus.ref_data = '0;
        tick(); tick();
        chk("rst_armed", armed, 0);
        chk("rst_trig", trig, 0);
        chk("rst_sad", sad_out, 0);
        chk("rst_min", sad_min, 20'hFFFFF);
        chk("rst_cnt", tcnt, 0);
        rst_n = 1'b1;

        // One-shot exact match
        load_refs(0);
        arm_tick(12'd2000, 0);
        repeat (20) push(12'd2000);
        pattern(-1, 0);
        watch(8, 12'd2000, first, pulses, sad4);
        chk("t1_first", first, 5);
        chk("t1_pulses", pulses, 1);
        chk("t1_sad", sad4, 0);
        chk("t1_armed", armed, 0);
        chk("t1_cnt", tcnt, 1);
        chk("t1_min", sad_min, 0);

        // Strict threshold: SAD 10 vs thr 10 then 11
        thr = 20'd10;
        arm_tick(12'd2000, 1);
        pattern(3, 12'd410);
        watch(8, 12'd2000, first, pulses, sad4);
        chk("t2_nopulse", pulses, 0);
        chk("t2_sad", sad4, 10);
        chk("t2_min", sad_min, 10);
        chk("t2_armed", armed, 1);
        thr = 20'd11;
        pattern(3, 12'd410);
        watch(8, 12'd2000, first, pulses, sad4);
        chk("t2_first", first, 5);
        chk("t2_cnt", tcnt, 2);

        // Excluded slot ignores a wild sample
        thr = 20'd1;
        excl = 8'h08;
        arm_tick(12'd2000, 0);
        pattern(3, 12'd4095);
        watch(8, 12'd2000, first, pulses, sad4);
        chk("t3_first", first, 5);
        chk("t3_sad", sad4, 0);
        chk("t3_cnt", tcnt, 3);
        excl = '0;

        // Continuous mode, holdoff 0 then 3
        adc = 12'd500;
        load_refs(1);
        aa = 1'b1;
        holdoff = '0;
        arm_tick(12'd500, 0);
        watch(20, 12'd500, first, pulses, sad4);
        chk("t4_first0", first, 13);
        chk("t4_pulses0", pulses, 8);
        chk("t4_cnt0", tcnt, 11);
        chk("t4_armed0", armed, 1);
        holdoff = 16'd3;
        arm_tick(12'd500, 0);
        chk("t4_armtrig", trig, 1);
        chk("t4_armarmed", armed, 1);
        chk("t4_armcnt", tcnt, 12);
        watch(28, 12'd500, first, pulses, sad4);
        chk("t4_first3", first, 13);
        chk("t4_pulses3", pulses, 4);
        chk("t4_cnt3", tcnt, 16);

        // Pattern straddling arm must not count
        thr = '0;
        aa = 1'b0;
        holdoff = '0;
        load_refs(0);
        thr = 20'd1;
        for (int i = 1; i <= 4; i++) push(12'(100 * i));
        arm_tick(12'd500, 1);
        for (int i = 6; i <= 8; i++) push(12'(100 * i));
        watch(5, 12'd2000, first, pulses, sad4);
        chk("t5_nopulse", pulses, 0);
        chk("t5_min", sad_min, 20'hFFFFF);
        chk("t5_armed", armed, 1);
        arm_tick(12'd2000, 0);
        pattern(-1, 0);
        watch(8, 12'd2000, first, pulses, sad4);
        chk("t5_first", first, 5);
        chk("t5_cnt", tcnt, 17);

        // Asynchronous reset mid-pattern
        arm_tick(12'd2000, 0);
        for (int i = 1; i <= 4; i++) push(12'(100 * i));
        rst_n = 1'b0;
        #1;
        chk("t6_armed", armed, 0);
        chk("t6_trig", trig, 0);
        chk("t6_sad", sad_out, 0);
        chk("t6_min", sad_min, 20'hFFFFF);
        chk("t6_cnt", tcnt, 0);
        tick(); tick();
        rst_n = 1'b1;
        load_refs(0);
        pattern(-1, 0);
        watch(8, 12'd2000, first, pulses, sad4);
        chk("t6_nopulse", pulses, 0);
        chk("t6_armed_after", armed, 0);
        chk("t6_cnt_after", tcnt, 0);
        chk("t6_sad_after", sad_out, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
